mem_arbiter: RTL and testbench

Two-port to single-port memory arbiter for the RV32 core: shares one unified instruction/data memory between the fetch port (driven by PC) and the load/store port (driven by the ALU address and RD2 write data). Sits between the core and the memory macro. Grants at most one request per cycle, routes the one-cycle-latency read response back to its owner, and bounds fetch starvation under continuous load/store traffic.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_starve_cnt.sv | 35 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
// Optional starvation guard is enabled by MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_IF,
    RSP_DM
  } rsp_tag_e;

  localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive fetch losses, with clear.
// Instantiated only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  localparam int W = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [W-1:0] cnt_d, cnt_q;

  assign at_max = (cnt_q == W'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter onto one single-port memory.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic                    dm_gnt,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  input  logic                    mem_ready,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  rsp_tag_e rsp_tag_d, rsp_tag_q;
  logic     force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic wait_inc, wait_clr;

  assign wait_inc = if_req && mem_ready && !if_gnt;
  assign wait_clr = mem_ready && (if_gnt || !if_req);

  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .at_max (force_if)
  );
`else
  // MAX_WAIT has no effect under strict dm-over-if priority
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT > 0);
  assign force_if        = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (mem_ready) begin
      if (if_req && (!dm_req || force_if))
        if_gnt = 1'b1;
      else if (dm_req)
        dm_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    rsp_tag_d = RSP_NONE;
    unique case (1'b1)
      if_gnt: begin
        mem_en    = 1'b1;
        mem_addr  = if_addr;
        mem_be    = '1;
        rsp_tag_d = RSP_IF;
      end
      dm_gnt: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
        rsp_tag_d = dm_we ? RSP_NONE : RSP_DM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      rsp_tag_q <= RSP_NONE;
    else
      rsp_tag_q <= rsp_tag_d;
  end

  // A response in flight when reset hits is dropped
  assign if_rvalid = !rst && (rsp_tag_q == RSP_IF);
  assign dm_rvalid = !rst && (rsp_tag_q == RSP_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; expectations follow the
// build's MEM_ARB_STARVE_GUARD_EN setting.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int prev_tag = 0;

  typedef struct {
    logic        ig, dg, en, we;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic        iv, dv;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_WAIT   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_ready (mem_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; grants are hand-computed per row
  task automatic vec(input logic r, ifr, input logic [31:0] ifa,
                     input logic dr, dwe, input logic [31:0] da, dwd,
                     input logic [3:0] dbe, input logic rdy,
                     input logic [31:0] rd, input logic eig, edg);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; if_req = ifr; if_addr = ifa;
    dm_req = dr; dm_we = dwe; dm_addr = da;
    dm_wdata = dwd; dm_be = dbe;
    mem_ready = rdy; mem_rdata = rd;
    e.ig   = eig;
    e.dg   = edg;
    e.en   = eig | edg;
    e.we   = edg & dwe;
    e.addr = eig ? ifa : (edg ? da : 32'h0);
    e.wd   = edg ? dwd : 32'h0;
    e.be   = eig ? 4'hF : (edg ? dbe : 4'h0);
    e.iv   = !r && (prev_tag == 1);
    e.dv   = !r && (prev_tag == 2);
    e.rd   = rd;
    prev_tag = r ? 0 : (eig ? 1 : ((edg && !dwe) ? 2 : 0));
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic r, input logic [31:0] rd);
    vec(r, 0, 0, 0, 0, 0, 0, 0, 1, rd, 0, 0);
  endtask

  task automatic both(input logic rdy, input logic [31:0] rd,
                      input logic eig, edg);
    vec(0, 1, 32'hC, 1, 0, 32'h300, 0, 4'hF, rdy, rd, eig, edg);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t m;
      m = exp_q.pop_front();
      chk("if_gnt",    {31'b0, if_gnt},    {31'b0, m.ig});
      chk("dm_gnt",    {31'b0, dm_gnt},    {31'b0, m.dg});
      chk("mem_en",    {31'b0, mem_en},    {31'b0, m.en});
      chk("mem_we",    {31'b0, mem_we},    {31'b0, m.we});
      chk("mem_addr",  mem_addr,           m.addr);
      chk("mem_wdata", mem_wdata,          m.wd);
      chk("mem_be",    {28'b0, mem_be},    {28'b0, m.be});
      chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, m.iv});
      chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, m.dv});
      if (m.iv) chk("if_rdata", if_rdata, m.rd);
      if (m.dv) chk("dm_rdata", dm_rdata, m.rd);
    end
  end

  initial begin
    rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_ready = 1;
    mem_rdata = 0;

    idle(1, 32'h0);
    idle(0, 32'h0);
    // fetch-only stream
    vec(0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
    vec(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h00500093, 1, 0);
    idle(0, 32'h00100113);
    // contention, then fetch alone once dm drops
    vec(0, 1, 32'h8, 1, 0, 32'h100, 0, 4'hF, 1, 32'h0, 0, 1);
    vec(0, 1, 32'h8, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0);
    // store: no response follows
    vec(0, 0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 4'hF, 1,
        32'h0000AAAA, 0, 1);
    idle(0, 32'h00005555);
    // sustained contention
    for (int i = 0; i < 10; i++) begin
      bit w;
      w = GUARD && (i % 5 == 4);
      both(1, 32'h1000 + i, w, !w);
    end
    // memory stalls hold the loss count
    both(1, 32'h2000, 0, 1);
    both(1, 32'h2001, 0, 1);
    both(0, 32'h2002, 0, 0);
    both(0, 32'h2003, 0, 0);
    both(0, 32'h2004, 0, 0);
    both(1, 32'h2005, 0, 1);
    both(1, 32'h2006, 0, 1);
    both(1, 32'h2007, GUARD, !GUARD);
    idle(0, 32'h2008);
    // reset drops an outstanding fetch response
    vec(0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
    idle(1, 32'h3000);
    idle(0, 32'h3001);
    // reset clears a partial loss count
    both(1, 32'h3002, 0, 1);
    both(1, 32'h3003, 0, 1);
    idle(1, 32'h3004);
    both(1, 32'h3005, 0, 1);
    both(1, 32'h3006, 0, 1);
    both(1, 32'h3007, 0, 1);
    both(1, 32'h3008, 0, 1);
    both(1, 32'h3009, GUARD, !GUARD);
    idle(0, 32'h300A);
    idle(0, 32'h300B);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
